// File: rtl/truth_table_sweeper.sv
// Sequential SOP/POS truth-table sweeper: streams every input row with both
// function outputs and a mismatch flag, then reports ones/mismatch statistics.
module truth_table_sweeper #(
  parameter int unsigned N_IN = 4,
  localparam int unsigned DEPTH = 2 ** N_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DEPTH-1:0]  min_mask,
  input  logic [DEPTH-1:0]  max_mask,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_IN-1:0]   vec,
  output logic              sop,
  output logic              pos,
  output logic              mism,
  output logic              done,
  output logic [N_IN:0]     ones_cnt,
  output logic [N_IN:0]     mism_cnt,
  output logic [N_IN-1:0]   first_mism,
  output logic              equiv
);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e             state_q;
  logic [N_IN-1:0]    idx_q;
  logic [DEPTH-1:0]   min_mask_q;
  logic [DEPTH-1:0]   max_mask_q;
  logic [N_IN:0]      ones_q;
  logic [N_IN:0]      mism_q;
  logic [N_IN-1:0]    first_q;
  logic               seen_q;
  logic               equiv_q;

  logic               xfer;
  logic [N_IN:0]      ones_d;
  logic [N_IN:0]      mism_d;

  assign out_valid = (state_q == StSweep);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  // Row outputs are gated by out_valid so everything reads 0 outside a sweep.
  assign vec  = idx_q;
  assign sop  = out_valid & min_mask_q[idx_q];
  assign pos  = out_valid & ~max_mask_q[idx_q];
  assign mism = sop ^ pos;

  assign xfer   = out_valid & out_ready;
  assign ones_d = ones_q + {{N_IN{1'b0}}, sop};
  assign mism_d = mism_q + {{N_IN{1'b0}}, mism};

  assign ones_cnt   = ones_q;
  assign mism_cnt   = mism_q;
  assign first_mism = first_q;
  assign equiv      = equiv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      min_mask_q <= '0;
      max_mask_q <= '0;
      ones_q     <= '0;
      mism_q     <= '0;
      first_q    <= '0;
      seen_q     <= 1'b0;
      equiv_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            min_mask_q <= min_mask;
            max_mask_q <= max_mask;
            idx_q      <= '0;
            ones_q     <= '0;
            mism_q     <= '0;
            first_q    <= '0;
            seen_q     <= 1'b0;
            state_q    <= StSweep;
          end
        end
        StSweep: begin
          if (xfer) begin
            ones_q <= ones_d;
            mism_q <= mism_d;
            if (mism && !seen_q) begin
              first_q <= idx_q;
              seen_q  <= 1'b1;
            end
            // Natural wrap of idx returns it to 0 after the last row.
            idx_q <= idx_q + N_IN'(1);
            if (&idx_q) begin
              equiv_q <= (mism_d == '0);
              state_q <= StDone;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: directed and randomized sweeps at N_IN=3 and
// N_IN=4 checked against a truth-table reference model computed from the masks.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        start3, ready3, busy3, valid3, sop3, pos3, mism3, done3, equiv3;
  logic [7:0]  min3, max3;
  logic [2:0]  vec3, first3;
  logic [3:0]  ones3, mc3;

  logic        start4, ready4, busy4, valid4, sop4, pos4, mism4, done4, equiv4;
  logic [15:0] min4, max4;
  logic [3:0]  vec4, first4;
  logic [4:0]  ones4, mc4;

  logic [7:0]  r8;

  truth_table_sweeper #(.N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .min_mask(min3), .max_mask(max3),
    .busy(busy3), .out_valid(valid3), .out_ready(ready3), .vec(vec3), .sop(sop3),
    .pos(pos3), .mism(mism3), .done(done3), .ones_cnt(ones3), .mism_cnt(mc3),
    .first_mism(first3), .equiv(equiv3)
  );

  truth_table_sweeper #(.N_IN(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .min_mask(min4), .max_mask(max4),
    .busy(busy4), .out_valid(valid4), .out_ready(ready4), .vec(vec4), .sop(sop4),
    .pos(pos4), .mism(mism4), .done(done4), .ones_cnt(ones4), .mism_cnt(mc4),
    .first_mism(first4), .equiv(equiv4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset3(input string tag);
    chk({tag, " valid"}, valid3, 0);
    chk({tag, " busy"}, busy3, 0);
    chk({tag, " vec"}, vec3, 0);
    chk({tag, " sop"}, sop3, 0);
    chk({tag, " pos"}, pos3, 0);
    chk({tag, " mism"}, mism3, 0);
    chk({tag, " done"}, done3, 0);
    chk({tag, " ones"}, ones3, 0);
    chk({tag, " mcnt"}, mc3, 0);
    chk({tag, " first"}, first3, 0);
    chk({tag, " equiv"}, equiv3, 1);
  endtask

  // mode 0: ready always high, 1: ready low on alternate cycles, 2: random ready.
  task automatic sweep3(input logic [7:0] mn, input logic [7:0] mx, input int mode,
                        input bit restart);
    int ones = 0, nm = 0, first = 0, beat = 0, el = 1, stalls = 0;
    bit seen = 0, pulsed = 0;
    logic s, p;
    for (int k = 0; k < 8; k++) begin
      s = mn[k];
      p = !mx[k];
      ones += int'(s);
      if (s != p) begin
        nm++;
        if (!seen) begin first = k; seen = 1; end
      end
    end
    min3 = mn; max3 = mx; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0; min3 = 8'($urandom); max3 = 8'($urandom);
    chk("n3 cleared ones", ones3, 0);
    chk("n3 cleared mcnt", mc3, 0);
    chk("n3 cleared first", first3, 0);
    while (beat < 8 && el < 200) begin
      case (mode)
        0: ready3 = 1'b1;
        1: ready3 = (el % 2 == 0);
        default: ready3 = 1'($urandom_range(0, 1));
      endcase
      chk("n3 valid", valid3, 1);
      chk("n3 busy", busy3, 1);
      chk("n3 vec", vec3, beat);
      chk("n3 sop", sop3, mn[beat]);
      chk("n3 pos", pos3, !mx[beat]);
      chk("n3 mism", mism3, mn[beat] != !mx[beat]);
      if (restart && beat == 4 && !pulsed) begin
        start3 = 1'b1; min3 = ~mn; max3 = ~mx; pulsed = 1;
      end
      if (ready3) beat++; else stalls++;
      @(posedge clk); #1;
      start3 = 1'b0;
      el++;
    end
    chk("n3 latency", el, 9 + stalls);
    chk("n3 done", done3, 1);
    chk("n3 done valid", valid3, 0);
    chk("n3 done busy", busy3, 1);
    chk("n3 ones", ones3, ones);
    chk("n3 mcnt", mc3, nm);
    chk("n3 first", first3, first);
    chk("n3 equiv", equiv3, nm == 0);
    @(posedge clk); #1;
    chk("n3 idle done", done3, 0);
    chk("n3 idle busy", busy3, 0);
    chk("n3 hold ones", ones3, ones);
    chk("n3 hold equiv", equiv3, nm == 0);
  endtask

  task automatic sweep4(input logic [15:0] mn, input logic [15:0] mx, input bit rnd);
    int ones = 0, nm = 0, first = 0, beat = 0, el = 1, stalls = 0;
    bit seen = 0;
    for (int k = 0; k < 16; k++) begin
      ones += int'(mn[k]);
      if (mn[k] == mx[k]) begin
        nm++;
        if (!seen) begin first = k; seen = 1; end
      end
    end
    min4 = mn; max4 = mx; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; min4 = 16'($urandom); max4 = 16'($urandom);
    while (beat < 16 && el < 400) begin
      ready4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("n4 valid", valid4, 1);
      chk("n4 vec", vec4, beat);
      chk("n4 sop", sop4, mn[beat]);
      chk("n4 pos", pos4, !mx[beat]);
      if (ready4) beat++; else stalls++;
      @(posedge clk); #1;
      el++;
    end
    chk("n4 latency", el, 17 + stalls);
    chk("n4 done", done4, 1);
    chk("n4 ones", ones4, ones);
    chk("n4 mcnt", mc4, nm);
    chk("n4 first", first4, first);
    chk("n4 equiv", equiv4, nm == 0);
    @(posedge clk); #1;
    chk("n4 idle done", done4, 0);
  endtask

  initial begin
    start3 = 0; ready3 = 0; min3 = '0; max3 = '0;
    start4 = 0; ready4 = 0; min4 = '0; max4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset3("por");
    chk("por n4 equiv", equiv4, 1);
    chk("por n4 ones", ones4, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset3("idle");

    sweep3(8'h67, 8'h98, 0, 0);
    sweep3(8'h67, 8'h90, 0, 0);
    sweep3(8'h67, 8'h98, 1, 0);
    sweep3(8'h35, 8'hA6, 0, 1);
    sweep3(8'hC3, 8'h3C, 0, 0);

    // Abort mid-sweep: reset lands between edges, during beat 5.
    min3 = 8'h67; max3 = 8'h90; start3 = 1'b1; ready3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort pre vec", vec3, 5);
    chk("abort pre mcnt", mc3, 1);
    #1 rst = 1'b1;
    #1;
    chk_reset3("abort");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst = 1'b0;
      chk("abort no done", done3, 0);
      chk("abort no busy", busy3, 0);
    end
    sweep3(8'h67, 8'h98, 0, 0);

    sweep4(16'hFFFF, 16'h0000, 0);
    for (int i = 0; i < 3; i++) sweep4(16'($urandom), 16'($urandom), 1);
    for (int i = 0; i < 5; i++) sweep3(8'($urandom), 8'($urandom), 2, 0);
    for (int i = 0; i < 2; i++) begin
      r8 = 8'($urandom);
      sweep3(r8, ~r8, 2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
